// File: rtl/seg7_pkg.sv
// seg7_pkg: character codes, glyph types and the code-to-segment decode table
// shared by the 7-segment scan multiplexer and its decoder.
package seg7_pkg;

   typedef logic [4:0] char_t;
   typedef logic [6:0] glyph_t;   // {g,f,e,d,c,b,a}, active-high

   localparam char_t CH_H      = 5'd16;
   localparam char_t CH_J      = 5'd17;
   localparam char_t CH_R      = 5'd18;
   localparam char_t CH_N      = 5'd19;
   localparam char_t CH_U      = 5'd20;
   localparam char_t CH_P      = 5'd21;
   localparam char_t CH_L      = 5'd22;
   localparam char_t CH_G      = 5'd23;
   localparam char_t CH_Y      = 5'd24;
   localparam char_t CH_T      = 5'd25;
   localparam char_t CH_O      = 5'd26;
   localparam char_t CH_C      = 5'd27;
   localparam char_t CH_DASH   = 5'd28;
   localparam char_t CH_UNDER  = 5'd29;
   localparam char_t CH_BLANK  = 5'd30;
   localparam char_t CH_BLANK2 = 5'd31;

   function automatic glyph_t decode(input char_t code);
      glyph_t g;
      case (code)
         5'h00:     g = 7'h3F;
         5'h01:     g = 7'h06;
         5'h02:     g = 7'h5B;
         5'h03:     g = 7'h4F;
         5'h04:     g = 7'h66;
         5'h05:     g = 7'h6D;
         5'h06:     g = 7'h7D;
         5'h07:     g = 7'h07;
         5'h08:     g = 7'h7F;
         5'h09:     g = 7'h6F;
         5'h0A:     g = 7'h77;
         5'h0B:     g = 7'h7C;
         5'h0C:     g = 7'h39;
         5'h0D:     g = 7'h5E;
         5'h0E:     g = 7'h79;
         5'h0F:     g = 7'h71;
         CH_H:      g = 7'h76;
         CH_J:      g = 7'h1E;
         CH_R:      g = 7'h50;
         CH_N:      g = 7'h54;
         CH_U:      g = 7'h3E;
         CH_P:      g = 7'h73;
         CH_L:      g = 7'h38;
         CH_G:      g = 7'h3D;
         CH_Y:      g = 7'h6E;
         CH_T:      g = 7'h78;
         CH_O:      g = 7'h5C;
         CH_C:      g = 7'h58;
         CH_DASH:   g = 7'h40;
         CH_UNDER:  g = 7'h08;
         default:   g = 7'h00;
      endcase
      return g;
   endfunction

   // Slot 0 drives the leftmost digit an[3], slot 3 the rightmost an[0].
   function automatic logic [3:0] digit_enable(input logic [1:0] slot);
      return 4'b1000 >> slot;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational character code to active-high 7-segment glyph.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = decode(code);
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit common-anode scan multiplexer with once-per-frame code snapshot.
// Define SEG7_BRIGHTNESS_EN to add the `bright` input and per-slot on-time PWM.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50_000,
   parameter int GUARD       = 64,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] A,
   input  logic [4:0] B,
   input  logic [4:0] C,
   input  logic [4:0] D,
   input  logic [3:0] dp_in,
   output logic [6:0] seg,
   output logic       seg_dp,
   output logic [3:0] an,
   output logic       frame_tick
`ifdef SEG7_BRIGHTNESS_EN
   ,
   input  logic [2:0] bright
`endif
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0] div_cnt;
   logic [1:0]    digit_idx;
   logic          first;
   char_t         snap [4];
   logic [3:0]    dp_snap;

   logic          slot_end;
   logic          load;
   logic          lit;
   logic          cur_dp;
   char_t         cur_code;
   glyph_t        glyph;
   logic [3:0]    an_sel;

`ifdef SEG7_BRIGHTNESS_EN
   logic [2:0]    bright_snap;
   logic [2:0]    cur_bright;
   logic [31:0]   on_len;
`endif

   always_comb begin
      slot_end = (div_cnt == CW'(REFRESH_DIV - 1));
      load     = first || (slot_end && (digit_idx == 2'd3));
      // first is only ever set in slot 0, so the live inputs stand in for the
      // snapshot that is being loaded this cycle.
      cur_code = first ? A : snap[digit_idx];
      cur_dp   = first ? dp_in[3] : dp_snap[~digit_idx];
      an_sel   = digit_enable(digit_idx);
      lit      = (div_cnt >= CW'(GUARD));
`ifdef SEG7_BRIGHTNESS_EN
      cur_bright = first ? bright : bright_snap;
      on_len     = ((32'(cur_bright) + 32'd1) * 32'(REFRESH_DIV - GUARD)) >> 3;
      lit        = lit && ((32'(div_cnt) - 32'(GUARD)) < on_len);
`endif
   end

   seg7_decode u_decode (
      .code  (cur_code),
      .glyph (glyph)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt    <= '0;
         digit_idx  <= '0;
         first      <= 1'b1;
         snap[0]    <= CH_BLANK;
         snap[1]    <= CH_BLANK;
         snap[2]    <= CH_BLANK;
         snap[3]    <= CH_BLANK;
         dp_snap    <= '0;
         frame_tick <= 1'b0;
         seg        <= {7{ACTIVE_LOW}};
         seg_dp     <= ACTIVE_LOW;
         an         <= {4{ACTIVE_LOW}};
`ifdef SEG7_BRIGHTNESS_EN
         bright_snap <= 3'd7;
`endif
      end else begin
         first      <= 1'b0;
         frame_tick <= load;
         if (load) begin
            snap[0] <= A;
            snap[1] <= B;
            snap[2] <= C;
            snap[3] <= D;
            dp_snap <= dp_in;
`ifdef SEG7_BRIGHTNESS_EN
            bright_snap <= bright;
`endif
         end
         if (slot_end) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         seg    <= glyph ^ {7{ACTIVE_LOW}};
         seg_dp <= cur_dp ^ ACTIVE_LOW;
         an     <= (lit ? an_sel : 4'b0000) ^ {4{ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: randomized scoreboard bench for seg7_scan_mux (REFRESH_DIV=8, GUARD=2, active-low).
// Works with or without SEG7_BRIGHTNESS_EN defined.
module tb_seg7_scan_mux;

   localparam int R  = 8;
   localparam int G  = 2;
   localparam int FR = 4 * R;

   typedef struct packed {
      logic [7:0]      chg;    // frame-relative cycle at which next frame's codes appear; FF = random
      logic [2:0]      br;
      logic [3:0]      dp;
      logic [3:0][4:0] code;   // code[0] = A (leftmost) .. code[3] = D
   } frame_t;

   typedef struct packed {
      logic [31:0] k;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic        tick;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] A, B, C, D;
   logic [3:0] dp_in;
   logic [6:0] seg;
   logic       seg_dp;
   logic [3:0] an;
   logic       frame_tick;
`ifdef SEG7_BRIGHTNESS_EN
   logic [2:0] bright;
`endif

   int     total = 0;
   int     bad   = 0;
   logic   mon_en = 1'b0;
   exp_t   q [$];
   frame_t plan [$];

   // Segment letters lit for each code, written straight from the character set.
   string seg_str [32] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg",
                           "bcefg", "bcde", "eg", "ceg", "bcdef", "abefg", "def", "acdef",
                           "bcdfg", "defg", "cdeg", "deg", "g", "d", "", ""};

   seg7_scan_mux #(
      .REFRESH_DIV (R),
      .GUARD       (G),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .A          (A),
      .B          (B),
      .C          (C),
      .D          (D),
      .dp_in      (dp_in),
      .seg        (seg),
      .seg_dp     (seg_dp),
      .an         (an),
      .frame_tick (frame_tick)
`ifdef SEG7_BRIGHTNESS_EN
      ,
      .bright     (bright)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph_of(input logic [4:0] c);
      string s;
      logic [6:0] g;
      s = seg_str[c];
      g = '0;
      for (int i = 0; i < s.len(); i++) g = g | (7'd1 << (int'(s[i]) - 97));
      return g;
   endfunction

   function automatic frame_t mk(input int a, input int b, input int c, input int d,
                                 input int dpv, input int brv, input int chg);
      frame_t r;
      r.code[0] = 5'(a);
      r.code[1] = 5'(b);
      r.code[2] = 5'(c);
      r.code[3] = 5'(d);
      r.dp      = 4'(dpv);
      r.br      = 3'(brv);
      r.chg     = 8'(chg);
      return r;
   endfunction

   function automatic frame_t rand_frame();
      return mk(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                int'($urandom_range(15, 0)), int'($urandom_range(7, 0)), 255);
   endfunction

   function automatic frame_t next_frame();
      if (plan.size() > 0) return plan.pop_front();
      return rand_frame();
   endfunction

   task automatic drive(input frame_t v);
      A     = v.code[0];
      B     = v.code[1];
      C     = v.code[2];
      D     = v.code[3];
      dp_in = v.dp;
`ifdef SEG7_BRIGHTNESS_EN
      bright = v.br;
`endif
   endtask

   // Expected outputs for the 4*R cycles a frame is on display, k0 = first edge index.
   task automatic push_frame(input frame_t v, input int k0);
      exp_t e;
      int   s, pos, k, b, on;
      b = int'(v.br);
`ifndef SEG7_BRIGHTNESS_EN
      b = 7;
`endif
      on = ((b + 1) * (R - G)) / 8;
      for (int j = 0; j < FR; j++) begin
         k      = k0 + j;
         s      = j / R;
         pos    = j % R;
         e.k    = 32'(k);
         e.an   = (pos >= G && (pos - G) < on) ? ~(4'b0001 << (3 - s)) : 4'hF;
         e.seg  = ~glyph_of(v.code[s]);
         e.dp   = ~v.dp[3 - s];
         e.tick = (k == 1) || (k % FR == 0);
         q.push_back(e);
      end
   endtask

   task automatic push_reset();
      exp_t e;
      e.k    = '0;
      e.an   = 4'hF;
      e.seg  = 7'h7F;
      e.dp   = 1'b1;
      e.tick = 1'b0;
      q.push_back(e);
   endtask

   // Caller holds reset high and is just past a rising edge.
   task automatic session(input int nframes, input int abort_frame, input int abort_j);
      frame_t cur, nxt;
      int     p, pj;
      cur = next_frame();
      drive(cur);
      push_frame(cur, 1);
      reset = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      for (int f = 0; f < nframes; f++) begin
         nxt = next_frame();
         p   = (cur.chg != 8'hFF) ? int'(cur.chg) : int'($urandom_range(FR - 2, 0));
         pj  = (p > 0) ? int'($urandom_range(p - 1, 0)) : -1;
         for (int j = 0; j < FR; j++) begin
            if (f == abort_frame && j == abort_j) begin
               reset  = 1'b1;
               mon_en = 1'b0;
               q.delete();
               @(posedge clk); #1;
               push_reset();
               return;
            end
            if (j == pj) drive(rand_frame());
            if (j == p) begin
               drive(nxt);
               push_frame(nxt, FR * (f + 1) + 1);
            end
            @(posedge clk); #1;
         end
         cur = nxt;
      end
      mon_en = 1'b0;
      q.delete();
   endtask

   always @(negedge clk) begin
      exp_t e;
      total++;
      if (!$onehot0(~an)) begin
         bad++;
         $display("FAIL an_onehot: got an=%b want at most one low bit", an);
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if ({an, seg, seg_dp, frame_tick} !== {e.an, e.seg, e.dp, e.tick}) begin
            bad++;
            $display("FAIL out k=%0d: got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                     e.k, an, seg, seg_dp, frame_tick, e.an, e.seg, e.dp, e.tick);
         end
      end else if (mon_en) begin
         total++;
         bad++;
         $display("FAIL underflow: got no expected entry want one per cycle");
      end
   end

   initial begin
      reset = 1'b1;
      drive(mk(30, 30, 30, 30, 0, 7, 255));
      repeat (3) begin
         @(posedge clk); #1;
         push_reset();
      end

      plan.push_back(mk(30, 30, 30, 30, 0, 7, 255));
      plan.push_back(mk(16, 14, 22, 22, 0, 7, 255));
      plan.push_back(mk(16, 14, 22, 22, 4'b0101, 7, R + 5));
      plan.push_back(mk(0, 14, 22, 22, 0, 3, 255));
      plan.push_back(mk(31, 29, 30, 8, 4'hF, 7, 255));
      plan.push_back(mk(16, 17, 18, 19, 4'b1000, 0, 255));
      plan.push_back(mk(20, 21, 22, 23, 4'b0001, 7, 255));
      plan.push_back(mk(24, 25, 26, 27, 0, 5, 255));
      plan.push_back(mk(28, 29, 30, 31, 0, 7, 255));
      plan.push_back(mk(10, 11, 12, 13, 0, 1, 255));
      session(14, -1, 0);

      reset = 1'b1;
      @(posedge clk); #1;
      push_reset();

      session(4, 2, 2 * R + 3);

      plan.push_back(mk(16, 14, 22, 21, 4'b0010, 7, 255));
      plan.push_back(mk(1, 2, 3, 4, 0, 6, 255));
      session(6, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
